// File: rtl/fib_pair_serializer.sv
// fib_pair_serializer: accepts word pairs and emits them one word at a time, oldest first.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   producer presents a pair (in_num older, in_num2 newer)
//   in_ready   at least two free entries; a pair can be accepted this cycle
//   in_num     first (older) word of the pair
//   in_num2    second (newer) word of the pair
//   out_valid  out_data holds the FIFO head
//   out_ready  consumer takes the head word this cycle
//   out_data   FIFO head word (registered storage)
//   wrap_seen  sticky: some emitted word was smaller than the word emitted before it
//   out_count  words emitted since reset, modulo 2^16
module fib_pair_serializer #(
    parameter int unsigned W     = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_num,
    input  logic [W-1:0] in_num2,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         wrap_seen,
    output logic [15:0]  out_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    // A pair needs two free slots, so pushes are allowed only up to DEPTH-2 occupancy.
    localparam logic [CntW-1:0] MaxFillForPush = CntW'(DEPTH - 2);
    localparam logic [PtrW-1:0] LastIdx        = PtrW'(DEPTH - 1);

    logic [W-1:0]    mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nxt;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [15:0]     out_count_q, out_count_d;
    logic [W-1:0]    last_q, last_d;
    logic            cmp_en_q, cmp_en_d;
    logic            wrap_q, wrap_d;
    logic            push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == LastIdx) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    // Gate with rst so in_ready reads 0 while reset is held, not just after it clears state.
    assign in_ready  = !rst && (count_q <= MaxFillForPush);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr_q];
    assign wrap_seen = wrap_q;
    assign out_count = out_count_q;

    assign push       = in_valid && in_ready;
    assign pop        = out_valid && out_ready;
    assign wr_ptr_nxt = ptr_inc(wr_ptr_q);

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_count_d = out_count_q;
        last_d      = last_q;
        cmp_en_d    = cmp_en_q;
        wrap_d      = wrap_q;

        if (push) begin
            wr_ptr_d = ptr_inc(wr_ptr_nxt);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(2);
            2'b01:   count_d = count_q - CntW'(1);
            2'b11:   count_d = count_q + CntW'(1);
            default: count_d = count_q;
        endcase

        if (pop) begin
            rd_ptr_d    = ptr_inc(rd_ptr_q);
            out_count_d = out_count_q + 16'd1;
            last_d      = out_data;
            cmp_en_d    = 1'b1;
            // The first pop after reset has no predecessor to compare against.
            if (cmp_en_q && (out_data < last_q)) begin
                wrap_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_count_q <= '0;
            last_q      <= '0;
            cmp_en_q    <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_count_q <= out_count_d;
            last_q      <= last_d;
            cmp_en_q    <= cmp_en_d;
            wrap_q      <= wrap_d;
        end
    end

    // Storage is intentionally not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q]   <= in_num;
            mem_q[wr_ptr_nxt] <= in_num2;
        end
    end

endmodule

// File: tb/tb_fib_pair_serializer.sv
// Directed self-checking bench for fib_pair_serializer (W=16, DEPTH=4).
module tb_fib_pair_serializer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_num;
    logic [15:0] in_num2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        wrap_seen;
    logic [15:0] out_count;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] popped[$];
    bit          rec;
    int          pop_n;
    bit          pushed_ok;
    int          accepted;
    logic [11:0] hist;
    logic [15:0] e031[6] = '{16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8};
    logic [15:0] e032[4] = '{16'd10, 16'd11, 16'd12, 16'd13};

    fib_pair_serializer #(.W(16), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_num    (in_num),
        .in_num2   (in_num2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .wrap_seen (wrap_seen),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Records what the coming edge will transfer, then advances to 1 time unit past it.
    task automatic tick();
        if (out_valid && out_ready) begin
            pop_n++;
            if (rec) popped.push_back(out_data);
        end
        pushed_ok = in_valid && in_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_num   = a;
        in_num2  = b;
        for (int i = 0; i < 20 && !done; i++) begin
            tick();
            done = pushed_ok;
        end
        in_valid = 1'b0;
        check("push_accepted", 32'(done), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_num    = '0;
        in_num2   = '0;
        out_ready = 1'b0;
        rec       = 1'b1;
        pop_n     = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_wrap", 32'(wrap_seen), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Fibonacci pairs, consumer always ready; first word visible right after accept
        out_ready = 1'b1;
        popped.delete();
        push_pair(16'd1, 16'd1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_data", 32'(out_data), 32'd1);
        push_pair(16'd2, 16'd3);
        push_pair(16'd5, 16'd8);
        repeat (8) tick();
        check("fib_n_pop", popped.size(), 32'd6);
        for (int i = 0; i < 6; i++) check("fib_word", 32'(popped[i]), 32'(e031[i]));
        check("fib_out_count", 32'(out_count), 32'd6);
        check("fib_wrap", 32'(wrap_seen), 32'd0);

        // Fill with consumer stalled: exactly two pairs fit
        out_ready = 1'b0;
        popped.delete();
        accepted  = 0;
        in_valid  = 1'b1;
        in_num    = 16'd10;
        in_num2   = 16'd11;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (pushed_ok) begin
                accepted++;
                in_num  = in_num + 16'd2;
                in_num2 = in_num2 + 16'd2;
            end
        end
        check("full_accepted", 32'(accepted), 32'd2);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_head", 32'(out_data), 32'd10);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("depth_m1_in_ready", 32'(in_ready), 32'd0);
        repeat (5) tick();
        check("drain_n_pop", popped.size(), 32'd4);
        for (int i = 0; i < 4; i++) check("drain_word", 32'(popped[i]), 32'(e032[i]));
        check("drain_out_count", 32'(out_count), 32'd10);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Sustained traffic: in_ready alternates after fill, one word per cycle out
        popped.delete();
        in_num    = 16'd20;
        in_num2   = 16'd21;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        hist      = '0;
        for (int i = 0; i < 12; i++) begin
            hist[i] = in_ready;
            tick();
            if (pushed_ok) begin
                in_num  = in_num + 16'd2;
                in_num2 = in_num2 + 16'd2;
            end
        end
        in_valid = 1'b0;
        check("stream_ready_hist", 32'(hist), 32'h0AAB);
        check("stream_n_pop", popped.size(), 32'd11);
        for (int i = 0; i < 11; i++) check("stream_word", 32'(popped[i]), 32'(20 + i));
        repeat (5) tick();
        check("stream_out_count", 32'(out_count), 32'd24);
        check("stream_wrap", 32'(wrap_seen), 32'd0);

        // Decreasing word sets the sticky wrap flag
        out_ready = 1'b0;
        push_pair(16'd28657, 16'd46368);
        push_pair(16'd9489, 16'd56393);
        out_ready = 1'b1;
        check("wrap_head0", 32'(out_data), 32'd28657);
        tick();
        check("wrap_after_p0", 32'(wrap_seen), 32'd0);
        check("wrap_head1", 32'(out_data), 32'd46368);
        tick();
        check("wrap_after_p1", 32'(wrap_seen), 32'd0);
        check("wrap_head2", 32'(out_data), 32'd9489);
        tick();
        check("wrap_after_p2", 32'(wrap_seen), 32'd1);
        check("wrap_head3", 32'(out_data), 32'd56393);
        tick();
        check("wrap_sticky", 32'(wrap_seen), 32'd1);
        check("wrap_out_count", 32'(out_count), 32'd28);

        // Asynchronous reset mid-cycle with three words buffered
        out_ready = 1'b0;
        push_pair(16'd100, 16'd101);
        push_pair(16'd102, 16'd103);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_arst_count", 32'(out_count), 32'd29);
        check("pre_arst_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_out_count", 32'(out_count), 32'd0);
        check("arst_wrap", 32'(wrap_seen), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_arst_in_ready", 32'(in_ready), 32'd1);
        check("post_arst_empty", 32'(out_valid), 32'd0);
        push_pair(16'd1, 16'd1);
        check("post_arst_head", 32'(out_data), 32'd1);
        popped.delete();
        out_ready = 1'b1;
        repeat (3) tick();
        check("post_arst_n_pop", popped.size(), 32'd2);
        check("post_arst_w0", 32'(popped[0]), 32'd1);
        check("post_arst_w1", 32'(popped[1]), 32'd1);
        check("post_arst_count", 32'(out_count), 32'd2);

        // 65536 pops bring out_count back to where it started
        rec       = 1'b0;
        pop_n     = 0;
        in_num    = 16'd7;
        in_num2   = 16'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 70000 && pop_n < 65536; c++) tick();
        in_valid = 1'b0;
        check("roll_pops", 32'(pop_n), 32'd65536);
        check("roll_out_count", 32'(out_count), 32'd2);
        check("roll_wrap", 32'(wrap_seen), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
